// File: rtl/inst_fetch_unit.sv
// Instruction fetch engine: issues reads to a one-cycle-latency ROM, buffers
// returned words in a small FIFO and hands them to decode over valid/ready.
module inst_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_code,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] tag_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];

    logic                  issue;
    logic                  pop;
    logic                  push;
    logic [OCC_W-1:0]      occupancy;

    assign inst_valid = (count_q != '0);
    assign inst_code  = inst_valid ? fifo_data[rd_ptr_q] : '0;
    assign inst_addr  = inst_valid ? fifo_addr[rd_ptr_q] : '0;
    assign pc         = pc_q;

    assign pop    = inst_valid & inst_ready;
    assign push   = inflight_q & ~redirect;
    assign rom_en = issue & rst;

    // Issue decision: redirect overrides; otherwise only issue if the word
    // will have a FIFO slot when it returns next cycle.
    always_comb begin
        issue     = 1'b0;
        rom_addr  = pc_q;
        pc_d      = pc_q;
        occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
        if (redirect) begin
            issue    = ~halt;
            rom_addr = redirect_addr;
            pc_d     = halt ? redirect_addr : redirect_addr + ADDR_WIDTH'(1);
        end else if (!halt && (occupancy < OCC_W'(FIFO_DEPTH))) begin
            issue = 1'b1;
            pc_d  = pc_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            pc_q       <= ADDR_WIDTH'(RESET_ADDR);
            inflight_q <= 1'b0;
            tag_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            tag_q      <= rom_addr;
            if (redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head.
    always_ff @(posedge clka) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= tag_q;
            fifo_data[wr_ptr_q] <= rom_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a queue-based reference model that
// is checked every cycle, plus literal checkpoints along the stimulus script.
module tb_inst_fetch_unit;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned AMASK = (1 << AW) - 1;

    logic          clka = 1'b0;
    logic          rst  = 1'b1;
    logic          halt = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b1;
    logic [DW-1:0] inst_code;
    logic [AW-1:0] inst_addr;
    logic [AW-1:0] pc;

    int total = 0;
    int bad   = 0;

    inst_fetch_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RESET_ADDR(0)
    ) dut (
        .clka(clka), .rst(rst), .halt(halt), .redirect(redirect),
        .redirect_addr(redirect_addr), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_code(inst_code), .inst_addr(inst_addr), .pc(pc)
    );

    always #5 clka = ~clka;

    function automatic logic [31:0] word(input int unsigned a);
        return 32'(a * 32'h0101_0101);
    endfunction

    // Synchronous ROM with one-cycle read latency
    always @(posedge clka) if (rom_en) rom_data <= word(int'(rom_addr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pc, one in-flight tag and a queue of buffered addresses
    int unsigned m_pc;
    bit          m_inf;
    int unsigned m_tag;
    int unsigned m_q[$];

    always @(negedge clka) begin
        bit          exp_valid;
        bit          m_pop;
        bit          m_issue;
        int unsigned exp_addr;
        if (!rst) begin
            m_pc = 0; m_inf = 0; m_tag = 0; m_q.delete();
            chk("rst_valid", 32'(inst_valid), 32'd0);
            chk("rst_rom_en", 32'(rom_en), 32'd0);
        end else begin
            exp_valid = (m_q.size() > 0);
            chk("m_valid", 32'(inst_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("m_addr", 32'(inst_addr), m_q[0]);
                chk("m_code", inst_code, word(m_q[0]));
            end
            chk("m_pc", 32'(pc), m_pc);
            m_pop = exp_valid && inst_ready;
            if (redirect) begin
                m_issue  = !halt;
                exp_addr = int'(redirect_addr);
            end else begin
                m_issue  = !halt && (m_q.size() + int'(m_inf) - int'(m_pop) < DEPTH);
                exp_addr = m_pc;
            end
            chk("m_rom_en", 32'(rom_en), 32'(m_issue));
            if (m_issue) chk("m_rom_addr", 32'(rom_addr), exp_addr);
            if (redirect) begin
                m_q.delete();
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_inf) m_q.push_back(m_tag);
            end
            if (redirect) m_pc = m_issue ? ((exp_addr + 1) & AMASK) : exp_addr;
            else if (m_issue) m_pc = (m_pc + 1) & AMASK;
            m_inf = m_issue;
            m_tag = exp_addr;
        end
    end

    task automatic cyc();
        @(posedge clka);
        #2;
    endtask

    task automatic head(input string name, input int unsigned a);
        chk({name, "_valid"}, 32'(inst_valid), 32'd1);
        chk({name, "_addr"}, 32'(inst_addr), a);
        chk({name, "_code"}, inst_code, word(a));
    endtask

    initial begin
        #1 rst = 1'b0;
        cyc(); cyc();
        chk("reset_valid", 32'(inst_valid), 32'd0);
        chk("reset_code", inst_code, 32'd0);
        chk("reset_addr", 32'(inst_addr), 32'd0);
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_rom_en", 32'(rom_en), 32'd0);

        // C0: first cycle out of reset issues RESET_ADDR
        cyc(); rst = 1'b1; #1;
        chk("c0_rom_en", 32'(rom_en), 32'd1);
        chk("c0_rom_addr", 32'(rom_addr), 32'd0);
        cyc();                                   // C1
        chk("c1_valid", 32'(inst_valid), 32'd0);
        cyc(); head("c2", 0);                    // C2
        cyc(); head("c3", 1);                    // C3: backpressure begins
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc();       // C4..C7
        head("bp_hold", 1);
        chk("bp_rom_en", 32'(rom_en), 32'd0);
        chk("bp_pc", 32'(pc), 32'd3);
        cyc(); inst_ready = 1'b1; #1;            // C8
        chk("bp_rel_rom_addr", 32'(rom_addr), 32'd3);
        cyc(); head("c9", 2);
        cyc(); head("c10", 3);                   // C10: fill FIFO again
        inst_ready = 1'b0;
        cyc();                                   // C11: FIFO full, redirect
        redirect = 1'b1; redirect_addr = 6'h20; inst_ready = 1'b1; #1;
        chk("rd_rom_addr", 32'(rom_addr), 32'h20);
        cyc(); redirect = 1'b0;                  // C12
        chk("rd_bubble", 32'(inst_valid), 32'd0);
        cyc(); head("rd_first", 32'h20);         // C13
        cyc(); head("rd_second", 32'h21);        // C14: redirect near top
        redirect = 1'b1; redirect_addr = 6'h3D;
        cyc(); redirect = 1'b0;                  // C15
        cyc(); head("wr_3d", 32'h3D);
        cyc(); head("wr_3e", 32'h3E);
        cyc(); head("wr_3f", 32'h3F);
        cyc(); head("wr_00", 32'h00);
        cyc(); head("wr_01", 32'h01);            // C20
        cyc(); head("h0", 32'h02);               // C21: halt for 4 cycles
        halt = 1'b1; #1;
        chk("h_rom_en", 32'(rom_en), 32'd0);
        chk("h_pc0", 32'(pc), 32'h04);
        cyc(); head("h1", 32'h03);
        cyc(); chk("h2_valid", 32'(inst_valid), 32'd0);
        cyc(); chk("h3_pc", 32'(pc), 32'h04);
        cyc(); halt = 1'b0; #1;                  // C25: resume at held pc
        chk("h_resume_en", 32'(rom_en), 32'd1);
        chk("h_resume_addr", 32'(rom_addr), 32'h04);
        cyc();
        cyc(); head("h_resume", 32'h04);         // C27
        cyc(); head("pre_rst", 32'h05);          // C28: reset mid-stream
        rst = 1'b0; #1;
        chk("mr_valid", 32'(inst_valid), 32'd0);
        chk("mr_code", inst_code, 32'd0);
        chk("mr_addr", 32'(inst_addr), 32'd0);
        chk("mr_pc", 32'(pc), 32'd0);
        chk("mr_rom_en", 32'(rom_en), 32'd0);
        cyc();
        cyc(); rst = 1'b1; #1;
        chk("mr_restart_addr", 32'(rom_addr), 32'd0);
        cyc();
        cyc(); head("mr_first", 0);
        cyc(); head("mr_second", 1);
        cyc(); cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Parametrised instruction-fetch unit for the EXPR-series CPU datapath. It generalises the fixed 6-bit-address, 32-bit-instruction fetch path into a configurable fetch engine. The engine drives a synchronous instruction ROM (one-cycle read latency) and buffers returned words in a small FIFO. It delivers them to decode over a valid/ready handshake, with halt and PC-redirect (branch/jump) support.

## Interface
- ADDR_WIDTH, 6: word-address width of PC and ROM.
- DATA_WIDTH, 32: instruction width.
- FIFO_DEPTH, 2: output buffer entries; power of two, ≥2.
- RESET_ADDR, 0: PC value after reset.

- clka  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- halt  in  1  1 = issue no new ROM reads, PC held.
- redirect  in  1  single-cycle request to restart fetch at redirect_addr.
- redirect_addr  in  ADDR_WIDTH  new fetch address.
- rom_en  out  1  ROM read strobe (combinational).
- rom_addr  out  ADDR_WIDTH  ROM read address (combinational).
- rom_data  in  DATA_WIDTH  ROM output; valid the cycle after rom_en.
- inst_valid  out  1  FIFO head holds an instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_code  out  DATA_WIDTH  head instruction.
- inst_addr  out  ADDR_WIDTH  address the head was fetched from.
- pc  out  ADDR_WIDTH  next sequential fetch address.

## Operation
- State:
  - pc register.
  - inflight flag (read issued last cycle) and its address tag.
  - FIFO of {addr, data} with count.
- pop = inst_valid & inst_ready.
- Issue condition, normal cycle: !halt & (count + inflight − pop < FIFO_DEPTH).
  - On issue: rom_en=1, rom_addr=pc, pc ← pc+1 (mod 2^ADDR_WIDTH, 2^ADDR_WIDTH−1 wraps to 0).
  - Otherwise rom_en=0 and pc holds.
- Response: when inflight=1, {tag, rom_data} is pushed into the FIFO this cycle. Space is guaranteed by the issue condition; overflow never occurs.
- Push and pop in the same cycle are both performed; count is unchanged.
- Redirect cycle (redirect=1), which takes priority over everything:
  - FIFO is flushed (count ← 0).
  - The response arriving this cycle is discarded, not pushed.
  - pop has no effect.
  - If !halt: rom_en=1, rom_addr=redirect_addr, pc ← redirect_addr+1.
  - If halt=1: no issue, pc ← redirect_addr.
- Halt only blocks new issue. The already in-flight response is still pushed, and the FIFO still drains.
- Reset (rst=0, any time, asynchronous):
  - pc=RESET_ADDR, inflight=0, count=0.
  - inst_valid=0; inst_code and inst_addr are 0.
  - rom_en=0 while rst=0. Any in-flight read is abandoned.

## Timing
- Read issued in cycle N: data pushed at the edge ending N+1; inst_valid=1 in cycle N+2.
- First rom_en (addr RESET_ADDR) occurs in the first cycle with rst=1. The first inst_valid follows two cycles later.
- With inst_ready held 1 and FIFO_DEPTH≥2: one instruction per cycle, consecutive addresses, no bubbles.
- inst_valid, inst_code and inst_addr come straight from registered FIFO state. They stay stable while inst_valid=1 & inst_ready=0.
- After redirect in cycle R: inst_valid=0 in R+1. The instruction from redirect_addr is presented in R+2 (absent halt).
- No instruction fetched before a redirect is ever presented after it.

## Test plan
- Sequential fetch: ROM word[a]=a·0x01010101, inst_ready=1, rst released. inst_valid rises 2 cycles later; inst_addr runs 0,1,2,… each cycle with matching inst_code.
- Backpressure: inst_ready=0 for 5 cycles mid-stream. At most FIFO_DEPTH entries are held and the head stays stable. rom_en stops after the FIFO fills; on release the order is unbroken, with no loss or duplication.
- Redirect: redirect=1, redirect_addr=0x20 while the FIFO is full. Next cycle inst_valid=0; the following cycle inst_addr=0x20; no stale address appears.
- Wrap-around (ADDR_WIDTH=6): the stream reaches 0x3F, then inst_addr=0x00, then 0x01.
- Halt: halt=1 for 4 cycles. The in-flight word is still delivered, then inst_valid=0. pc holds; fetch resumes at the held pc.
- Reset mid-operation: rst=0 with FIFO non-empty and a read in flight. Outputs clear immediately; after release, fetch restarts at RESET_ADDR.
